// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: N-bit adder/subtractor split into SEG-bit slices, one
// slice per stage, with the ripple carry registered between stages.
// Valid/ready handshake with a global stall, ADD/SUB/SLT/SLTU modes and a
// full flag set. Latency is STAGES = N/SEG cycles, throughput one per cycle.
// Optional build macro ADDSUB_SAT_EN: ADD/SUB results saturate on signed
// overflow (flags and SLT/SLTU results unchanged).
module pipelined_add_sub #(
    parameter int N   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         c_out,
    output logic         overflow,
    output logic         zero,
    output logic         negative,
    output logic         lt,
    output logic         ltu
);

    localparam int STAGES = N / SEG;

    logic stall;
    logic sub0;

    // Global stall: a presented result that is not taken freezes every stage
    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ~stall;
        sub0     = (op != 2'b00);
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // Width of the still-unprocessed y' bits entering this stage
            localparam int BW = N - k * SEG;

            // st_a: finished sum slices below k*SEG, raw x bits above
            logic [N-1:0]  st_a;
            logic [BW-1:0] st_b;
            logic          st_c;
            logic          st_v;
            logic [1:0]    st_op;
            logic [SEG:0]  slice_sum;
            logic [N-1:0]  a_nxt;

            if (k == 0) begin : g_src
                // First stage takes operands from the ports; subtract folds into y' and carry-in
                always_comb begin
                    st_a  = x;
                    st_b  = y ^ {N{sub0}};
                    st_c  = sub0;
                    st_v  = in_valid;
                    st_op = op;
                end
            end else begin : g_src
                // Later stages take the skewed operands from the previous stage register
                always_comb begin
                    st_a  = g_stage[k-1].g_reg.a_q;
                    st_b  = g_stage[k-1].g_reg.b_q;
                    st_c  = g_stage[k-1].g_reg.c_q;
                    st_v  = g_stage[k-1].g_reg.v_q;
                    st_op = g_stage[k-1].g_reg.op_q;
                end
            end

            // Add slice k with the carry handed down and splice the sum slice in
            always_comb begin
                slice_sum = {1'b0, st_a[k*SEG +: SEG]} + {1'b0, st_b[SEG-1:0]}
                          + {{SEG{1'b0}}, st_c};
                a_nxt = st_a;
                a_nxt[k*SEG +: SEG] = slice_sum[SEG-1:0];
            end

            if (k < STAGES - 1) begin : g_reg
                logic                v_q;
                logic                c_q;
                logic [1:0]          op_q;
                logic [N-1:0]        a_q;
                logic [BW-SEG-1:0]   b_q;

                // Stage valid bit: cleared on reset, advances whenever not stalled
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        v_q <= 1'b0;
                    end else if (!stall) begin
                        v_q <= st_v;
                    end
                end

                // Stage data: carry, op and skewed operands move with the transaction
                always_ff @(posedge clk) begin
                    if (!stall) begin
                        c_q  <= slice_sum[SEG];
                        op_q <= st_op;
                        a_q  <= a_nxt;
                        b_q  <= st_b[BW-1:SEG];
                    end
                end
            end else begin : g_out
                logic         ovf;
                logic         lt_f;
                logic         ltu_f;
                logic [N-1:0] res_f;

                // Final stage: flags from the full sum and the op-selected result
                always_comb begin
                    ovf   = (st_a[N-1] == st_b[BW-1]) & (a_nxt[N-1] != st_a[N-1]);
                    lt_f  = a_nxt[N-1] ^ ovf;
                    ltu_f = ~slice_sum[SEG];
                    case (st_op)
                        2'b10:   res_f = {{(N-1){1'b0}}, lt_f};
                        2'b11:   res_f = {{(N-1){1'b0}}, ltu_f};
                        default: res_f = a_nxt;
                    endcase
`ifdef ADDSUB_SAT_EN
                    // Both operands share x's sign on overflow, so x's sign picks the rail
                    if (!st_op[1] && ovf) begin
                        res_f = st_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                    end
`endif
                end

                // Output register: cleared on reset, held during a stall
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        out_valid <= 1'b0;
                        result    <= '0;
                        c_out     <= 1'b0;
                        overflow  <= 1'b0;
                        zero      <= 1'b0;
                        negative  <= 1'b0;
                        lt        <= 1'b0;
                        ltu       <= 1'b0;
                    end else if (!stall) begin
                        out_valid <= st_v;
                        if (st_v) begin
                            result   <= res_f;
                            c_out    <= slice_sum[SEG];
                            overflow <= ovf;
                            zero     <= (a_nxt == '0);
                            negative <= a_nxt[N-1];
                            lt       <= lt_f;
                            ltu      <= ltu_f;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the single-cycle N-bit adder/subtractor.
- Splits the N-bit operation into SEG-bit slices, one slice per stage, with the ripple carry registered between stages.
- Adds a valid/ready handshake with backpressure, ADD/SUB/SLT/SLTU modes, and a full flag set.
- Sits between the operand mux and writeback in multi-cycle or pipelined ALU configurations.

Parameters:
- N, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, slice width per stage; pipeline depth is STAGES = N/SEG (1 when SEG = N).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block accepts a transaction this cycle
- x  in  N  operand X
- y  in  N  operand Y
- op  in  2  00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  N  sum/difference, or {N-1 zeros, flag} for SLT/SLTU
- c_out  out  1  carry out of MSB (SUB: 1 means no borrow)
- overflow  out  1  signed overflow of the add/sub
- zero  out  1  add/sub value == 0
- negative  out  1  bit N-1 of the add/sub value
- lt  out  1  signed x < y (valid for every op)
- ltu  out  1  unsigned x < y (valid for every op)

Behaviour:
- Reset (async, rst_n = 0): every stage valid cleared; all outputs 0, including out_valid, result and flags. in_ready = 1 once rst_n deasserts.
- Internally y' = y XOR {N{sub}} with carry-in = sub, where sub = 1 for SUB/SLT/SLTU. SLT/SLTU always compute x - y.
- Stage k (0..STAGES-1):
  - adds slice k of x and y' with the carry registered from stage k-1;
  - registers the sum slice and carry;
  - carries the upper unprocessed operand slices and the lower finished sum slices forward (skew/deskew) with the transaction.
- Latency: exactly STAGES cycles from accept (in_valid & in_ready) to out_valid with no stall. Throughput: 1 per cycle.
- Flags are computed in the final stage from the full sum S:
  - overflow = (x[N-1] == y'[N-1]) & (S[N-1] != x[N-1])
  - lt = S[N-1] XOR overflow
  - ltu = ~c_out
  - zero = (S == 0); negative = S[N-1]
- result = S for ADD/SUB; {0, lt} for SLT; {0, ltu} for SLTU.
- Backpressure: global stall = out_valid & ~out_ready.
  - During a stall all stage registers hold and outputs are stable.
  - in_ready = ~stall (combinational).
- Bubbles: stage valid bits propagate independently; empty stages advance even when downstream holds nothing. No transaction is duplicated or dropped.
- Simultaneous accept and output handshake in the same cycle is legal; the pipeline shifts.
- Reset mid-operation: all in-flight transactions are discarded; no partial output.
- Inputs are don't-care when in_valid = 0. Stage data registers need not be reset; valid bits must be.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: ADD/SUB results saturate on signed overflow:
  - positive overflow -> 0x7FFF_FFFF (N=32);
  - negative overflow -> 0x8000_0000;
  - overflow flag still reports 1;
  - SLT/SLTU and the c_out/lt/ltu flags are unaffected.
- Undefined: result wraps modulo 2^N; no extra logic or ports.

Test Plan (N=32, SEG=8, STAGES=4):
- ADD x=0xFFFF_FFFF, y=0x0000_0001 -> after 4 cycles result=0, c_out=1, zero=1, overflow=0.
- SUB x=0x8000_0000, y=1 -> result=0x7FFF_FFFF, overflow=1, lt=1, ltu=0. With ADDSUB_SAT_EN -> result=0x8000_0000.
- SLT x=0xFFFF_FFFE, y=2 -> result=1. SLTU with the same operands -> result=0, ltu=0.
- Back-to-back: 8 random ops with in_valid held high -> 8 consecutive out_valid cycles; results match a reference model in order.
- Backpressure: out_ready=0 for 5 cycles with pipeline full -> in_ready=0, result/flags stable. Release -> all 4 drain in order, none lost or duplicated.
- Assert rst_n=0 with 3 transactions in flight -> out_valid=0 immediately and all outputs 0. After release, the first new op appears exactly 4 cycles after accept.
